// File: rtl/song_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : song_reader_if
// Brief    : Control, ROM and note-player signals of the song reader.
// Revision : 1.0
// ============================================================================
interface song_reader_if #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6
);
  logic                          play;
  logic [SONG_BITS-1:0]          song;
  logic                          beat;
  logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
  logic [NOTE_W+DUR_W-1:0]       rom_dout;
  logic                          new_note;
  logic [NOTE_W-1:0]             note;
  logic [DUR_W-1:0]              duration;
  logic                          playing;
  logic                          song_done;

  modport master (
    input  play, song, beat, rom_dout,
    output rom_addr, new_note, note, duration, playing, song_done
  );

  modport slave (
    output play, song, beat, rom_dout,
    input  rom_addr, new_note, note, duration, playing, song_done
  );
endinterface
`default_nettype wire

// File: rtl/song_reader.sv
`default_nettype none
// ============================================================================
// Module   : song_reader
// Brief    : Walks one song slot of the ROM and issues {note, duration} per entry,
//            holding each note for its duration in beat ticks.
// Revision : 1.0
// ============================================================================
module song_reader #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6
) (
  input logic           clk,
  input logic           reset,
  song_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);
  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;
  localparam logic [DUR_W-1:0]    DUR_ONE  = DUR_W'(1);

  state_t               state_q, state_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic [DUR_W-1:0]     remaining_q, remaining_d;
  logic                 done_lock_q, done_lock_d;
  logic [NOTE_W-1:0]    note_q, note_d;
  logic [DUR_W-1:0]     duration_q, duration_d;
  logic                 new_note_q, new_note_d;

  logic [NOTE_W-1:0]    w_rom_note;
  logic [DUR_W-1:0]     w_rom_dur;
  logic                 w_song_change;

  assign w_rom_note    = bus.rom_dout[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur     = bus.rom_dout[DUR_W-1:0];
  assign w_song_change = (bus.song != song_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    song_d      = song_q;
    remaining_d = remaining_q;
    done_lock_d = done_lock_q;
    note_d      = note_q;
    duration_d  = duration_q;
    new_note_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A finished song stays finished until play drops or the song changes
        if (done_lock_q) begin
          if (!bus.play || w_song_change) begin
            done_lock_d = 1'b0;
          end
        end else if (bus.play) begin
          song_d  = bus.song;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (w_song_change) begin
          song_d      = bus.song;
          idx_d       = '0;
          remaining_d = '0;
        end else begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (w_song_change) begin
          song_d      = bus.song;
          idx_d       = '0;
          remaining_d = '0;
          state_d     = S_FETCH;
        end else if (w_rom_dur == '0) begin
          state_d = S_DONE;
        end else begin
          note_d      = w_rom_note;
          duration_d  = w_rom_dur;
          remaining_d = w_rom_dur;
          new_note_d  = 1'b1;
          state_d     = S_PLAY;
        end
      end

      S_PLAY: begin
        if (w_song_change) begin
          song_d      = bus.song;
          idx_d       = '0;
          remaining_d = '0;
          state_d     = S_FETCH;
        end else if (bus.beat && bus.play) begin
          remaining_d = remaining_q - DUR_ONE;
          if (remaining_q == DUR_ONE) begin
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              state_d = S_FETCH;
            end
          end
        end
      end

      S_DONE: begin
        idx_d       = '0;
        done_lock_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      song_q      <= '0;
      remaining_q <= '0;
      done_lock_q <= 1'b0;
      note_q      <= '0;
      duration_q  <= '0;
      new_note_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      song_q      <= song_d;
      remaining_q <= remaining_d;
      done_lock_q <= done_lock_d;
      note_q      <= note_d;
      duration_q  <= duration_d;
      new_note_q  <= new_note_d;
    end
  end

  assign bus.rom_addr  = {song_q, idx_q};
  assign bus.new_note  = new_note_q;
  assign bus.note      = note_q;
  assign bus.duration  = duration_q;
  assign bus.playing   = (state_q == S_PLAY) && bus.play;
  assign bus.song_done = (state_q == S_DONE);

endmodule
`default_nettype wire
